seven_seg_mux_n: RTL and testbench
==================================

// Module: seven_seg_mux_n
// PURPOSE
//  Parametrised N-digit time-multiplexed seven-segment driver. Scans NUM_DIGITS hex digits at a programmable refresh rate.
//  Per-digit decimal points and enable mask. Inter-digit blanking interval against ghosting.
//  Display values are double-buffered and change only on frame boundaries, so there is no tearing.
//  Sits between the datapath (value producer) and the board-level segment/anode pins.
// PARAMETERS
//  NUM_DIGITS     4        digits scanned, legal 1..8
//  REFRESH_DIV    100000   clk cycles per digit slot, >= 2
//  BLANK_CYCLES   16       cycles at slot start with all anodes off, must be < REFRESH_DIV
//  SEG_ACTIVE_LOW 1        1: segment/dp outputs active-low; 0: active-high
//  AN_ACTIVE_LOW  1        1: anode outputs active-low; 0: active-high
// PORTS (one clock; reset is asynchronous and active-low)
//  clk           in   1              system clock
//  rst           in   1              asynchronous, active-low reset
//  value_in      in   4*NUM_DIGITS   hex nibbles, digit 0 = [3:0]
//  dp_in         in   NUM_DIGITS     decimal point per digit, 1 = lit
//  digit_en      in   NUM_DIGITS     1 = digit shown, 0 = blanked
//  load          in   1              capture value_in/dp_in/digit_en into pending buffer
//  seg_output    out  7              segments {g,f,e,d,c,b,a}, bit0 = a
//  dp_output     out  1              decimal point
//  anode_output  out  NUM_DIGITS     digit select, one-hot active
//  frame_done    out  1              1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  - Reset: cnt=0, idx=0, pending_valid=0.
//    Display and pending buffers = 0; digit_en buffer = 0, so everything is blanked.
//    seg_output = all off, dp_output off, anode_output all inactive, frame_done=0.
//  - Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
//  - idx advances on tick and wraps NUM_DIGITS-1 -> 0. frame_done = tick && idx==NUM_DIGITS-1, registered.
//  - load=1: pending buffer <= inputs, pending_valid <= 1. A later load overwrites the earlier one (last wins).
//  - Frame boundary (tick && idx==NUM_DIGITS-1): if pending_valid, display <= pending and pending_valid <= 0.
//  - load on the boundary cycle: display <= inputs directly, pending_valid <= 0.
//  - Outputs are registered: the value shown in cycle t+1 reflects cnt/idx/display in cycle t.
//  - Blanking: cnt < BLANK_CYCLES, or digit_en[idx]==0 -> anodes all inactive, segments all off, dp off.
//  - Otherwise: anode_output has only bit idx active; seg_output = hex pattern of nibble idx; dp_output = dp[idx].
//  - Active-low hex table: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000.
//    8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//    SEG_ACTIVE_LOW=0 inverts the table.
//  - Reset mid-frame: immediate return to reset values; pending data is lost.
//  - NUM_DIGITS=1: idx stays 0 and every tick is a frame boundary.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined: scanning from digit NUM_DIGITS-1 downward, a digit is blanked while
//    nibble==0 and dp==0 and every higher digit is also blanked this way.
//    Digit 0 is never suppressed. Suppression is computed on the display buffer.
//  - Undefined: zeros are displayed normally; only digit_en blanks.
// STRUCTURE
//  - Package seven_seg_pkg holds:
//    - SEG_OFF_AL = 7'b1111111;
//    - function hex_to_seg(nibble) returning the active-low table;
//    - localparam for idx width = $clog2(NUM_DIGITS), min 1.
//  - Sub-module seven_seg_decoder: combinational nibble -> 7-bit pattern, polarity-parameterised.
//    One instance, fed by the selected nibble.
// TESTING (sim with REFRESH_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4)
//  1. Hold rst=0 mid-scan -> anode_output=4'b1111, seg_output=7'h7F, frame_done=0 while low.
//  2. load value_in=16'h12AF, digit_en=4'hF, run one frame -> next frame shows F,A,2,1 on anodes 1110,1101,1011,0111;
//     each slot's first cycle blanked; frame_done every 16 cycles.
//  3. load 16'h1111 mid-frame -> current frame unchanged; new value appears from the first slot after frame_done.
//  4. load on the boundary cycle with 16'h5555 -> the next slot shows 5 immediately; a second load mid-frame wins over a first.
//  5. digit_en=4'b0101, dp_in=4'b0001 -> slots 1 and 3 fully blank; dp_output lit only in slot 0.
//  6. With LEADING_ZERO_BLANK_EN, value 16'h0070 -> digits 3,2 blank, digit 1 shows 7, digit 0 shows 0.
//     Without the macro, all four digits are shown.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// The segment table is active-low: bit0 = a ... bit6 = g.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF_AL = 7'b1111111;
  localparam int         IDX_W_MIN  = 1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_OFF_AL;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF_AL;
    endcase
    return seg;
  endfunction

  // Digit index width; a single-digit display still needs a 1-bit index.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : IDX_W_MIN;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to seven-segment pattern, output polarity selectable.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] seg_al;

  assign seg_al = hex_to_seg(nibble);
  assign seg    = ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_seg_mux_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg_output,
  output logic                    dp_output,
  output logic [NUM_DIGITS-1:0]   anode_output,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             tick, last_slot, boundary;

  logic [NUM_DIGITS-1:0][3:0] disp_val, pend_val;
  logic [NUM_DIGITS-1:0]      disp_dp, disp_en, pend_dp, pend_en;
  logic                       pend_valid;

  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_en, sel_sup, blank;
  logic [6:0]            seg_pat;
  logic [NUM_DIGITS-1:0] onehot;

  assign tick      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_slot = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary  = tick && last_slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= last_slot ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load that coincides with the frame boundary bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_en    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
    end else if (load && boundary) begin
      disp_val   <= value_in;
      disp_dp    <= dp_in;
      disp_en    <= digit_en;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_val   <= value_in;
      pend_dp    <= dp_in;
      pend_en    <= digit_en;
      pend_valid <= 1'b1;
    end else if (boundary && pend_valid) begin
      disp_val   <= pend_val;
      disp_dp    <= pend_dp;
      disp_en    <= pend_en;
      pend_valid <= 1'b0;
    end
  end

  assign sel_nib = disp_val[idx];
  assign sel_dp  = disp_dp[idx];
  assign sel_en  = disp_en[idx];
  assign onehot  = NUM_DIGITS'(1) << idx;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_sup;

  // Walk down from the top digit; suppression stops at the first non-zero or dp-lit digit.
  always_comb begin
    logic run;
    run    = 1'b1;
    lz_sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run       = run && (disp_val[i] == 4'h0) && !disp_dp[i];
      lz_sup[i] = run;
    end
  end

  assign sel_sup = lz_sup[idx];
`else
  assign sel_sup = 1'b0;
`endif

  assign blank = (cnt < CNT_W'(BLANK_CYCLES)) || !sel_en || sel_sup;

  seven_seg_decoder #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
  ) u_decoder (
    .nibble (sel_nib),
    .seg    (seg_pat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_output   <= SEG_OFF;
      dp_output    <= DP_OFF;
      anode_output <= AN_OFF;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (blank) begin
        seg_output   <= SEG_OFF;
        dp_output    <= DP_OFF;
        anode_output <= AN_OFF;
      end else begin
        seg_output   <= seg_pat;
        dp_output    <= (SEG_ACTIVE_LOW != 0) ? ~sel_dp : sel_dp;
        anode_output <= (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Directed bench for seven_seg_mux_n with a 4-cycle slot and 1-cycle blanking (16-cycle frame).
// Build with LEADING_ZERO_BLANK_EN to match an RTL built with leading-zero suppression.
module tb_seven_seg_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [6:0]  seg_output;
  logic        dp_output;
  logic [3:0]  anode_output;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [12:0] IDLE = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_mux_n #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .value_in     (value_in),
    .dp_in        (dp_in),
    .digit_en     (digit_en),
    .load         (load),
    .seg_output   (seg_output),
    .dp_output    (dp_output),
    .anode_output (anode_output),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {anode_output, seg_output, dp_output, frame_done};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed={an,seg,dp,fd}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks 16 cycles that start right after a frame_done cycle (or reset release).
  // Optional loads are driven in the cycle after step la / lb.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] en,
                             input logic [3:0] dp, input int la, input logic [15:0] lval,
                             input logic [3:0] len, input logic [3:0] ldp, input int lb,
                             input logic [15:0] lbval);
    logic [3:0]  sup;
    logic [12:0] e;
    int          slot, ph;
    sup = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int s = 3; s >= 1; s--) begin
        run    = run && (val[s*4 +: 4] == 4'h0) && !dp[s];
        sup[s] = run;
      end
    end
`endif
    for (int j = 1; j <= 16; j++) begin
      step();
      slot = (j - 1) / 4;
      ph   = (j - 1) % 4;
      if (ph == 0 || !en[slot] || sup[slot]) e = IDLE;
      else e = {~(4'b0001 << slot), tbl[val[slot*4 +: 4]], ~dp[slot], 1'b0};
      e[0] = (j == 16);
      chk($sformatf("%s_c%0d", tag, j), e);
      if (j == la) begin
        load = 1'b1; value_in = lval; digit_en = len; dp_in = ldp;
      end else if (j == lb) begin
        load = 1'b1; value_in = lbval;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; value_in = '0; dp_in = '0; digit_en = '0; load = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_async", IDLE);
    repeat (3) begin
      step();
      chk("rst_hold", IDLE);
    end
    @(negedge clk) rst = 1'b1;

    check_frame("f0_blank", 16'h0000, 4'h0, 4'h0, 2, 16'h12AF, 4'hF, 4'h0, 0, 16'h0);
    check_frame("f1_12af",  16'h12AF, 4'hF, 4'h0, 5, 16'h1111, 4'hF, 4'h0, 0, 16'h0);
    check_frame("f2_1111",  16'h1111, 4'hF, 4'h0, 15, 16'h5555, 4'hF, 4'h0, 0, 16'h0);
    check_frame("f3_5555",  16'h5555, 4'hF, 4'h0, 3, 16'h1234, 4'b0101, 4'b0001, 9, 16'hABCD);
    check_frame("f4_en_dp", 16'hABCD, 4'b0101, 4'b0001, 4, 16'h0070, 4'hF, 4'h0, 0, 16'h0);
    check_frame("f5_zeros", 16'h0070, 4'hF, 4'h0, 0, 16'h0, 4'h0, 4'h0, 0, 16'h0);

    step();
    load = 1'b1; value_in = 16'h8888; digit_en = 4'hF; dp_in = 4'h0;
    step();
    load = 1'b0;
    repeat (3) step();
    #2 rst = 1'b0;
    #1 chk("rst_mid_async", IDLE);
    repeat (2) begin
      step();
      chk("rst_mid_hold", IDLE);
    end
    @(negedge clk) rst = 1'b1;

    check_frame("post_rst_a", 16'h0000, 4'h0, 4'h0, 0, 16'h0, 4'h0, 4'h0, 0, 16'h0);
    check_frame("post_rst_b", 16'h0000, 4'h0, 4'h0, 0, 16'h0, 4'h0, 4'h0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
